ts_sync_aligner: RTL and testbench
==================================

# ts_sync_aligner

Per-channel MPEG-2 TS packet aligner that turns a raw byte stream (valid + 8-bit data) into a packet-aligned stream carrying a first-byte `sync` marker. It hunts for the 0x47 sync byte, confirms it over consecutive 188-byte packets, then flywheels through isolated sync errors. It sits directly upstream of `packet_loss_counter`, one instance per channel, and drives that block's `valid`, `sync` and `ts_data` inputs. It also counts lock losses for QoS reporting.

## Interface
- `PKT_LEN`, 188, bytes per TS packet.
- `SYNC_BYTE`, 8'h47, sync byte value.
- `LOCK_COUNT`, 3, consecutive sync hits required to declare lock (range 2..15).
- `UNLOCK_COUNT`, 3, consecutive sync misses while locked that drop lock (range 1..15).
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: `in_data` carries a byte this cycle.
- `in_data` in 8: raw TS byte.
- `en_reset_counter` in 1: synchronous clear of `loss_count`.
- `out_valid` out 1: `out_data` is an aligned packet byte.
- `out_sync` out 1: `out_data` is byte 0 of a packet. Only asserted with `out_valid`.
- `out_data` out 8: aligned byte.
- `locked` out 1: FSM is in LOCKED.
- `loss_count` out 8: number of LOCKED→HUNT transitions, saturating.

## Operation
- Byte position counter `pos` runs 0..PKT_LEN-1 and wraps to 0. It advances only on `in_valid`.
- Gaps with `in_valid`=0 freeze all state.
- A byte is "at boundary" when `pos`==0 on an accepted byte.
- HUNT:
  - On an accepted byte equal to SYNC_BYTE: go to VERIFY, set `pos`←1, set `hits`←1.
  - Otherwise remain in HUNT. `pos` is don't-care in this state.
- VERIFY:
  - At a boundary byte equal to SYNC_BYTE: `hits`++.
  - If `hits`+1 == LOCK_COUNT: go to LOCKED and set `miss`←0.
  - At a boundary byte not equal to SYNC_BYTE: go to HUNT. That byte is not re-examined as a new sync candidate.
- LOCKED:
  - A boundary byte equal to SYNC_BYTE sets `miss`←0.
  - A boundary byte not equal to SYNC_BYTE increments `miss`.
  - If `miss`+1 == UNLOCK_COUNT: go to HUNT and increment `loss_count`, saturating at 255.
  - Otherwise stay LOCKED (flywheel).
- Output qualification uses the next state, `ns`:
  - `out_valid` ← `in_valid` && `ns`==LOCKED.
  - `out_sync` ← `in_valid` && boundary && `ns`==LOCKED.
  - The byte that completes lock is emitted with `out_sync`=1.
  - Flywheeled boundary bytes are emitted with `out_sync`=1 and their actual (bad) data.
  - The byte that drops lock is not emitted.
- `en_reset_counter` clears `loss_count` to 0. If it coincides with a loss event, the clear wins and the result is 0.
- A byte is only ever compared when `in_valid`=1. Data on `in_valid`=0 cycles is ignored.

## Timing
- Latency is 1 cycle. `out_*` and `locked` are registered from the input cycle.
- Reset (`reset_n`=0 at an edge) forces the following, regardless of other inputs:
  - state HUNT, `pos`/`hits`/`miss` 0
  - `out_valid`=0, `out_sync`=0, `out_data`=0
  - `locked`=0, `loss_count`=0
- Reset mid-packet discards alignment. The next cycle starts in HUNT.
- `locked` rises in the same cycle as `out_sync` for the lock-completing byte. It falls in the cycle after the dropping byte is accepted.
- Back-to-back valid bytes are sustained at 1 byte/cycle with no stall. There is no backpressure.

## Structure
- Package `ts_pkg`:
  - `TS_PKT_LEN`=188
  - `TS_SYNC_BYTE`=8'h47
  - state enum `ts_sync_state_t` {HUNT, VERIFY, LOCKED}
  - shared by this block and `packet_loss_counter`.
- No sub-module. Single FSM plus counters.
- The four-channel top instantiates four copies ahead of the four `packet_loss_counter` instances.

## Test plan
- Clean stream: 0x47 every 188 bytes starting at byte 0, continuous valid.
  - First `out_valid`/`out_sync`/`locked` appears one cycle after input byte 376.
  - `out_sync` then recurs every 188 bytes with `out_data`=0x47.
- Single corrupted sync (0x46) at byte 752 while locked:
  - Byte is emitted with `out_sync`=1, `out_data`=0x46.
  - `locked` stays 1 and `loss_count` stays 0.
- Three consecutive bad syncs at bytes 752, 940, 1128:
  - `locked` drops after byte 1128, which is not emitted.
  - `loss_count`=1.
  - Relock with clean stream one cycle after byte 1128+376.
- False sync: 0x47 at byte 5 of noise, next boundary byte 193 = 0x00.
  - Returns to HUNT, no `out_valid` ever.
- Random `in_valid` gaps, ~50% duty, on a clean stream:
  - Lock is reached after the 3rd sync byte.
  - `out_sync` spacing is 188 valid bytes. Output matches input order exactly.
- Assert `en_reset_counter` in the same cycle as the 3rd miss:
  - `loss_count`=0 afterwards.
- Separately, assert `reset_n`=0 while locked:
  - Next cycle all outputs are 0.

Source files
------------

// File: rtl/ts_sync_aligner_pkg.sv
// Shared MPEG-2 TS definitions for the sync aligner and the packet loss counter.
// Holds packet geometry, the sync byte value and the alignment state encoding.
package ts_pkg;

    localparam int         TS_PKT_LEN   = 188;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } ts_sync_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ts_sync_aligner.sv
// Per-channel TS packet aligner: hunts for the sync byte, verifies it over
// consecutive packets, flywheels through isolated misses and counts lock losses.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// HUNT   | searching every accepted byte for the sync byte
// VERIFY | candidate found, confirming sync at successive packet boundaries
// LOCKED | aligned; bytes forwarded, boundary misses tolerated up to a limit
module ts_sync_aligner
    import ts_pkg::*;
#(
    parameter int         PKT_LEN      = TS_PKT_LEN,
    parameter logic [7:0] SYNC_BYTE    = TS_SYNC_BYTE,
    parameter int         LOCK_COUNT   = 3,
    parameter int         UNLOCK_COUNT = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       en_reset_counter,
    output logic       out_valid,
    output logic       out_sync,
    output logic [7:0] out_data,
    output logic       locked,
    output logic [7:0] loss_count
);

    localparam int               POS_W      = $clog2(PKT_LEN);
    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(PKT_LEN - 1);
    localparam logic [POS_W-1:0] POS_FIRST  = POS_W'(1);
    localparam logic [3:0]       LOCK_TGT   = 4'(LOCK_COUNT);
    localparam logic [3:0]       UNLOCK_TGT = 4'(UNLOCK_COUNT);

    ts_sync_state_t   state;
    ts_sync_state_t   ns;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_nx;
    logic [3:0]       hits;
    logic [3:0]       hits_nx;
    logic [3:0]       miss;
    logic [3:0]       miss_nx;
    logic             boundary;
    logic             is_sync;
    logic             loss_evt;

    assign boundary = (pos == '0);
    assign is_sync  = (in_data == SYNC_BYTE);

    always_comb begin
        ns       = state;
        pos_nx   = pos;
        hits_nx  = hits;
        miss_nx  = miss;
        loss_evt = 1'b0;

        if (in_valid) begin
            pos_nx = (pos == POS_LAST) ? '0 : pos + POS_FIRST;
            unique case (state)
                HUNT: begin
                    // The candidate byte itself is position 0 of its packet.
                    if (is_sync) begin
                        ns      = VERIFY;
                        pos_nx  = POS_FIRST;
                        hits_nx = 4'd1;
                    end else begin
                        pos_nx = '0;
                    end
                end
                VERIFY: begin
                    if (boundary) begin
                        if (is_sync) begin
                            hits_nx = hits + 4'd1;
                            if (hits + 4'd1 == LOCK_TGT) begin
                                ns      = LOCKED;
                                miss_nx = 4'd0;
                            end
                        end else begin
                            ns = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        if (is_sync) begin
                            miss_nx = 4'd0;
                        end else if (miss + 4'd1 == UNLOCK_TGT) begin
                            ns       = HUNT;
                            miss_nx  = 4'd0;
                            loss_evt = 1'b1;
                        end else begin
                            miss_nx = miss + 4'd1;
                        end
                    end
                end
                default: ns = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= HUNT;
            pos        <= '0;
            hits       <= 4'd0;
            miss       <= 4'd0;
            out_valid  <= 1'b0;
            out_sync   <= 1'b0;
            out_data   <= 8'd0;
            locked     <= 1'b0;
            loss_count <= 8'd0;
        end else begin
            state     <= ns;
            pos       <= pos_nx;
            hits      <= hits_nx;
            miss      <= miss_nx;
            out_valid <= in_valid && (ns == LOCKED);
            out_sync  <= in_valid && boundary && (ns == LOCKED);
            locked    <= (ns == LOCKED);
            if (in_valid) begin
                out_data <= in_data;
            end
            // A clear coinciding with a loss event leaves the counter at zero.
            if (en_reset_counter) begin
                loss_count <= 8'd0;
            end else if (loss_evt) begin
                loss_count <= sat_inc8(loss_count);
            end
        end
    end

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Scoreboard bench for ts_sync_aligner: directed TS streams push expected
// aligned bytes, a negedge monitor pops and compares every emitted byte.
module tb_ts_sync_aligner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       en_reset_counter;
    logic       out_valid;
    logic       out_sync;
    logic [7:0] out_data;
    logic       locked;
    logic [7:0] loss_count;

    typedef struct {
        logic       sync;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   bad_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   clr_idx  = -1;
    bit   gaps     = 1'b0;
    bit   mon_en   = 1'b0;

    ts_sync_aligner dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .en_reset_counter (en_reset_counter),
        .out_valid        (out_valid),
        .out_sync         (out_sync),
        .out_data         (out_data),
        .locked           (locked),
        .loss_count       (loss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (!out_valid) begin
                check("out_sync_without_valid", out_sync, 1'b0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_sync", out_sync, e.sync);
            end
        end
    end

    function automatic bit is_bad(input int idx);
        foreach (bad_q[k]) if (bad_q[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        in_valid         = 1'b0;
        in_data          = 8'h47;
        en_reset_counter = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit emit, input bit sy, input bit clr);
        if (emit) exp_q.push_back('{sync: sy, data: d});
        in_valid         = 1'b1;
        in_data          = d;
        en_reset_counter = clr;
        @(posedge clk);
        #1;
        in_valid         = 1'b0;
        in_data          = 8'h47;
        en_reset_counter = 1'b0;
    endtask

    // Byte i of a stream: sync every 188 bytes, filler i%70 never equals 0x46/0x47.
    task automatic stream(input int n, input int emit_from, input int emit_to, input string tag);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            bit         em;
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) idle();
            end
            d  = is_bad(i) ? 8'h46 : ((i % 188 == 0) ? 8'h47 : 8'(i % 70));
            em = (i >= emit_from) && (i < emit_to);
            send_byte(d, em, (i % 188 == 0), (i == clr_idx));
            check({tag, "_locked"}, locked, em);
        end
        idle();
        check({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_n          = 1'b0;
        in_valid         = 1'b0;
        in_data          = 8'h00;
        en_reset_counter = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        mon_en = 1'b1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_locked", locked, 1'b0);
        check("reset_loss_count", loss_count, 8'd0);

        // Clean stream with a single corrupted sync at 752: flywheel keeps lock.
        bad_q = '{752};
        stream(188 * 6, 376, 188 * 6, "clean_single_miss");
        check("single_miss_loss_count", loss_count, 8'd0);

        // Three consecutive misses drop lock, then a fresh clean stream relocks.
        do_reset();
        bad_q = '{752, 940, 1128};
        stream(1129, 376, 1128, "triple_miss");
        check("triple_miss_loss_count", loss_count, 8'd1);
        bad_q.delete();
        stream(600, 376, 600, "relock");
        check("relock_loss_count", loss_count, 8'd1);
        en_reset_counter = 1'b1;
        @(posedge clk);
        #1;
        en_reset_counter = 1'b0;
        check("clear_loss_count", loss_count, 8'd0);

        // False sync at byte 5 of noise, next boundary byte 193 is 0x00.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            logic [7:0] d;
            d = (i == 5) ? 8'h47 : ((i == 193) ? 8'h00 : 8'(i % 70));
            send_byte(d, 1'b0, 1'b0, 1'b0);
            check("false_sync_locked", locked, 1'b0);
        end
        idle();
        check("false_sync_queue_drained", exp_q.size(), 0);

        // Random in_valid gaps with 0x47 on the idle cycles.
        do_reset();
        gaps = 1'b1;
        stream(800, 376, 800, "gaps");
        gaps = 1'b0;

        // Counter clear coinciding with the dropping miss.
        do_reset();
        bad_q   = '{752, 940, 1128};
        clr_idx = 1128;
        stream(1129, 376, 1128, "clear_on_loss");
        check("clear_on_loss_count", loss_count, 8'd0);
        clr_idx = -1;
        bad_q.delete();

        // Reset while locked, with a sync byte presented on the reset edge.
        do_reset();
        stream(400, 376, 400, "pre_reset");
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h47;
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sync", out_sync, 1'b0);
        check("rst_out_data", out_data, 8'd0);
        check("rst_locked", locked, 1'b0);
        check("rst_loss_count", loss_count, 8'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        idle();
        check("final_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
